clkmon: RTL
===========

CLKMON -- requirements
Module: clkmon

Interface
REQ-001 Parameter CNT_W, default 16: width of the period counter and the measurement outputs.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on sig_in, minimum 2.
REQ-003 Parameter LOCK_COUNT, default 4: number of consecutive in-tolerance measurements needed to lock.
REQ-004 Parameter TIMEOUT, default 1024: number of clk_in cycles without an edge that counts as signal loss; must be less than 2^CNT_W.
REQ-005 clk_in  input  1  sole clock; all state on rising edge.
REQ-006 rst_in  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  monitor enable; low forces IDLE.
REQ-008 sig_in  input  1  divided clock or toggle under test; may be asynchronous to clk_in.
REQ-009 expected_half  input  CNT_W  nominal half-period, in clk_in cycles.
REQ-010 tol  input  CNT_W  allowed absolute deviation from expected_half.
REQ-011 rise_pulse  output  1  one-cycle pulse per synchronized rising edge.
REQ-012 fall_pulse  output  1  one-cycle pulse per synchronized falling edge.
REQ-013 half_period  output  CNT_W  last measured edge-to-edge interval.
REQ-014 period_valid  output  1  one-cycle pulse when half_period updates.
REQ-015 locked  output  1  high in state LOCKED.
REQ-016 lost  output  1  high in state LOST.

Function
REQ-017 sig_in SHALL pass through SYNC_STAGES flops, then one history flop; rise_pulse and fall_pulse SHALL be registered and assert SYNC_STAGES+1 clk_in edges after the first edge that samples the new sig_in level.
REQ-018 Counter cnt SHALL load 1 on a detected edge (either polarity), otherwise increment, saturating at 2^CNT_W-1.
REQ-019 On a detected edge, when a prior edge exists since entering ACQUIRE, half_period SHALL load cnt and period_valid SHALL pulse in the same cycle; a toggle with period 8 clk_in cycles yields 4.
REQ-020 The first edge after IDLE SHALL NOT produce period_valid.
REQ-021 A measurement SHALL match when |half_period_new - expected_half| <= tol, computed at CNT_W+1 bits without wrap; expected_half and tol are sampled at the measurement cycle.
REQ-022 FSM states: IDLE, ACQUIRE, LOCKED, LOST.
REQ-023 IDLE -> ACQUIRE on the first detected edge while en=1; the match count clears.
REQ-024 ACQUIRE: a match increments the match count and a mismatch clears it; reaching LOCK_COUNT -> LOCKED; cnt reaching TIMEOUT -> IDLE.
REQ-025 LOCKED: a mismatch or cnt reaching TIMEOUT -> LOST.
REQ-026 LOST: the next detected edge -> ACQUIRE with the match count cleared and no period_valid.
REQ-027 An edge and a timeout in the same cycle: the edge SHALL take priority.
REQ-028 en=0 SHALL force IDLE next cycle and clear cnt, the match count and the pulses; half_period SHALL hold.
REQ-029 locked and lost SHALL be registered state decodes and never both high.

Reset
REQ-030 rst_in high SHALL asynchronously clear all flops: synchronizer, history, cnt, match count, half_period=0, all outputs 0, state IDLE.
REQ-031 Reset release SHALL take effect on the next clk_in edge; a sig_in level present at release SHALL NOT generate a pulse.

Structure
REQ-032 Shared package clkmon_pkg SHALL hold the FSM state encoding and the default parameter values.
REQ-033 The synchronizer SHALL be a separate sub-module sync_ff (parameter STAGES, async reset to 0); all remaining logic stays in clkmon.

Verification
REQ-034 Stimulus: sig_in from a divide-by-8 source, expected_half=4, tol=0 -> period_valid every 4 cycles with half_period=4, locked high after 4 matches.
REQ-035 Stimulus: while locked, hold sig_in static for 1024 cycles -> lost rises on the timeout cycle; the next edge enters ACQUIRE.
REQ-036 Stimulus: one half-period of 6 with expected_half=4, tol=1 -> mismatch, LOCKED -> LOST; with tol=2 -> match, remains locked.
REQ-037 Stimulus: assert rst_in mid-LOCKED, asynchronous to the clock -> all outputs 0 immediately, no pulse on release with sig_in=1.
REQ-038 Stimulus: drop en for 3 cycles while locked -> IDLE, locked=0, half_period held; re-enable -> first edge gives no period_valid.
REQ-039 Stimulus: fully asynchronous sig_in jittered ±1 cycle around half-period 10 with tol=1 -> lock held, exactly one rise_pulse or fall_pulse per sig_in transition.

Source files
------------

// File: rtl/clkmon_pkg.sv
//------------------------------------------------------------------------------
// clkmon_pkg : shared FSM encoding and default parameters for the clock monitor
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clkmon_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int LOCK_COUNT_DEF  = 4;
  localparam int TIMEOUT_DEF     = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
//------------------------------------------------------------------------------
// sync_ff : multi-stage flop synchronizer, asynchronous reset to 0
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/clkmon.sv
//------------------------------------------------------------------------------
// clkmon : measures edge-to-edge intervals of sig_in and tracks frequency lock
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clkmon
  import clkmon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] expected_half,
  input  logic [CNT_W-1:0] tol,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam int LCK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [ARM_W-1:0] ARM_FULL  = ARM_W'(SYNC_STAGES + 1);
  localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync_lvl;
  logic             hist_q,  hist_d;
  logic [ARM_W-1:0] arm_q,   arm_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [LCK_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] hp_q,    hp_d;
  logic             pv_q,    pv_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;
  state_e           state_q, state_d;

  logic             edge_det;
  logic             in_tol;
  logic             timeout;
  logic [CNT_W-1:0] diff;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk_in),
    .rst (rst_in),
    .d   (sig_in),
    .q   (sync_lvl)
  );

  // Edges are ignored until the history flop holds a post-reset sample,
  // so a static level at reset release never looks like a transition.
  always_comb begin
    hist_d   = sync_lvl;
    arm_d    = (arm_q == ARM_FULL) ? arm_q : arm_q + ARM_W'(1);
    edge_det = en && (arm_q == ARM_FULL) && (sync_lvl != hist_q);
    diff     = (cnt_q >= expected_half) ? (cnt_q - expected_half)
                                        : (expected_half - cnt_q);
    in_tol   = (diff <= tol);
    timeout  = (cnt_q >= TMO);
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    hp_d    = hp_q;
    pv_d    = 1'b0;
    rise_d  = edge_det & sync_lvl;
    fall_d  = edge_det & ~sync_lvl;
    cnt_d   = edge_det ? CNT_ONE : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE);

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      match_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (edge_det) begin
            state_d = ST_ACQUIRE;
            match_d = '0;
          end
        end
        ST_ACQUIRE: begin
          if (edge_det) begin
            pv_d = 1'b1;
            hp_d = cnt_q;
            if (in_tol) begin
              match_d = match_q + LCK_W'(1);
              if (match_q == LOCK_LAST) state_d = ST_LOCKED;
            end else begin
              match_d = '0;
            end
          end else if (timeout) begin
            state_d = ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (edge_det) begin
            pv_d = 1'b1;
            hp_d = cnt_q;
            if (!in_tol) state_d = ST_LOST;
          end else if (timeout) begin
            state_d = ST_LOST;
          end
        end
        ST_LOST: begin
          if (edge_det) begin
            state_d = ST_ACQUIRE;
            match_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hist_q  <= 1'b0;
      arm_q   <= '0;
      cnt_q   <= '0;
      match_q <= '0;
      hp_q    <= '0;
      pv_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      hist_q  <= hist_d;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      hp_q    <= hp_d;
      pv_q    <= pv_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      state_q <= state_d;
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign half_period  = hp_q;
  assign period_valid = pv_q;
  assign locked       = (state_q == ST_LOCKED);
  assign lost         = (state_q == ST_LOST);

endmodule

`default_nettype wire
